// File: rtl/demux_4bit_capture_if.sv
// Handshake and data bus for the 4-way capture block. The master drives the
// shared data bus and control; the slave (capture block) returns the held
// channel registers, per-channel flags and the frame pulse.
interface demux_4bit_capture_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             c1;
    logic             c0;
    logic             in_valid;
    logic             in_ready;
    logic             auto_mode;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       vld;
    logic             frame_done;

    modport master (
        output din, c1, c0, in_valid, auto_mode, clr,
        input  in_ready, a, b, c, d, vld, frame_done
    );

    modport slave (
        input  din, c1, c0, in_valid, auto_mode, clr,
        output in_ready, a, b, c, d, vld, frame_done
    );
endinterface

// File: rtl/demux_4bit_capture.sv
// Capture end of the 4-way selection path: steers the shared bus into one of
// four held registers, either by {c1,c0} or by an auto-incrementing frame index.
//
// state | meaning
// FILL  | accepting beats (unless clr is high)
// DONE  | one-cycle frame-complete slot: frame_done=1, in_ready=0, vld cleared at its end
module demux_4bit_capture #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input logic                  clk,
    input logic                  rst_n,
    demux_4bit_capture_if.slave  bus
);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_eff;
    state_t           w_state_nxt;
    logic [1:0]       r_idx;
    logic [1:0]       w_idx_eff;
    logic [1:0]       w_idx_nxt;
    logic [1:0]       w_target;
    logic             r_auto_prev;
    logic             w_mode_chg;
    logic             w_ready;
    logic             w_accept;
    logic             r_frame_done;
    logic [3:0]       r_vld;
    logic [3:0]       w_vld_nxt;
    logic [WIDTH-1:0] r_regs [4];

    // A mode change restarts the frame in the same cycle, so a beat arriving
    // with the new mode already sees idx=0 and the FILL state.
    always_comb begin
        w_mode_chg  = (bus.auto_mode != r_auto_prev);
        w_idx_eff   = w_mode_chg ? 2'd0 : r_idx;
        w_state_eff = w_mode_chg ? ST_FILL : r_state;
        w_ready     = rst_n && !bus.clr && (w_state_eff == ST_FILL);
        w_accept    = bus.in_valid && w_ready;
        w_target    = bus.auto_mode ? w_idx_eff : {bus.c1, bus.c0};
    end

    // Next-state, index and flag logic; clr overrides everything else.
    always_comb begin
        w_state_nxt = w_state_eff;
        w_idx_nxt   = w_idx_eff;
        w_vld_nxt   = (r_state == ST_DONE) ? 4'b0000 : r_vld;
        if (bus.clr) begin
            w_state_nxt = ST_FILL;
            w_idx_nxt   = 2'd0;
            w_vld_nxt   = 4'b0000;
        end else begin
            if (w_state_eff == ST_DONE) begin
                w_state_nxt = ST_FILL;
            end
            if (!bus.auto_mode) begin
                w_idx_nxt = 2'd0;
            end else if (w_accept) begin
                w_idx_nxt = w_idx_eff + 2'd1;
                if (w_idx_eff == 2'd3) begin
                    w_state_nxt = ST_DONE;
                end
            end
            if (w_accept) begin
                w_vld_nxt[w_target] = 1'b1;
            end
        end
    end

    // Sequencer state, frame index, mode history and frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FILL;
            r_idx        <= 2'd0;
            r_auto_prev  <= 1'b0;
            r_vld        <= 4'b0000;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_auto_prev  <= bus.auto_mode;
            r_vld        <= w_vld_nxt;
            r_frame_done <= (w_state_nxt == ST_DONE);
        end
    end

    // Channel registers: only the targeted one loads on an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= RST_VAL;
        end else if (bus.clr) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= RST_VAL;
        end else if (w_accept) begin
            r_regs[w_target] <= bus.din;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.a          = r_regs[0];
    assign bus.b          = r_regs[1];
    assign bus.c          = r_regs[2];
    assign bus.d          = r_regs[3];
    assign bus.vld        = r_vld;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_demux_4bit_capture.sv
// Directed bench for demux_4bit_capture: stimulus pushes hand-computed
// expected snapshots per cycle; a negedge monitor pops and compares them.
module tb_demux_4bit_capture;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;

    demux_4bit_capture_if #(.WIDTH(4)) bus ();

    demux_4bit_capture #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      nm;
        int         cyc;
        logic [3:0] a, b, c, d, vld;
        logic       fd, rdy;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [21:0] act, req;
            e = q.pop_front();
            act = {bus.a, bus.b, bus.c, bus.d, bus.vld, bus.frame_done, bus.in_ready};
            req = {e.a, e.b, e.c, e.d, e.vld, e.fd, e.rdy};
            n_checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d", e.nm, e.cyc, cyc);
            end else if (act !== req) begin
                $display("FAIL %s (cycle %0d): got a=%h b=%h c=%h d=%h vld=%b fd=%b rdy=%b, want a=%h b=%h c=%h d=%h vld=%b fd=%b rdy=%b",
                         e.nm, cyc, bus.a, bus.b, bus.c, bus.d, bus.vld, bus.frame_done, bus.in_ready,
                         e.a, e.b, e.c, e.d, e.vld, e.fd, e.rdy);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic tick(input logic [3:0] din_v, input logic [1:0] sel,
                        input logic vl, input logic am, input logic cl);
        @(posedge clk);
        #1;
        bus.din       = din_v;
        bus.c1        = sel[1];
        bus.c0        = sel[0];
        bus.in_valid  = vl;
        bus.auto_mode = am;
        bus.clr       = cl;
    endtask

    task automatic expect_now(input string nm, input logic [3:0] ea, input logic [3:0] eb,
                              input logic [3:0] ec, input logic [3:0] ed, input logic [3:0] ev,
                              input logic efd, input logic erdy);
        exp_t e;
        e.nm = nm; e.cyc = cyc;
        e.a = ea; e.b = eb; e.c = ec; e.d = ed; e.vld = ev;
        e.fd = efd; e.rdy = erdy;
        q.push_back(e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus.din = 4'h0; bus.c1 = 1'b0; bus.c0 = 1'b0;
        bus.in_valid = 1'b0; bus.auto_mode = 1'b0; bus.clr = 1'b0;

        // reset
        tick(4'h0, 2'd0, 0, 0, 0); expect_now("reset",      4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0);
        tick(4'h0, 2'd0, 0, 0, 0); rst_n = 1'b1;
                                   expect_now("post_reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 1);

        // direct mode
        tick(4'h1, 2'd0, 1, 0, 0); expect_now("dir_beat_a", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 1);
        tick(4'h2, 2'd1, 1, 0, 0); expect_now("dir_a",      4'h1, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1);
        tick(4'hD, 2'd2, 1, 0, 0); expect_now("dir_b",      4'h1, 4'h2, 4'h0, 4'h0, 4'b0011, 0, 1);
        tick(4'h2, 2'd3, 1, 0, 0); expect_now("dir_c",      4'h1, 4'h2, 4'hD, 4'h0, 4'b0111, 0, 1);
        tick(4'h0, 2'd0, 0, 0, 0); expect_now("dir_d",      4'h1, 4'h2, 4'hD, 4'h2, 4'b1111, 0, 1);

        // auto frame: 3,7,9,F with select held at 11
        tick(4'h3, 2'd3, 1, 1, 0); expect_now("auto_b0",    4'h1, 4'h2, 4'hD, 4'h2, 4'b1111, 0, 1);
        tick(4'h7, 2'd3, 1, 1, 0); expect_now("auto_a",     4'h3, 4'h2, 4'hD, 4'h2, 4'b1111, 0, 1);
        tick(4'h9, 2'd3, 1, 1, 0); expect_now("auto_b",     4'h3, 4'h7, 4'hD, 4'h2, 4'b1111, 0, 1);
        tick(4'hF, 2'd3, 1, 1, 0); expect_now("auto_c",     4'h3, 4'h7, 4'h9, 4'h2, 4'b1111, 0, 1);
        tick(4'hE, 2'd3, 1, 1, 0); expect_now("auto_done",  4'h3, 4'h7, 4'h9, 4'hF, 4'b1111, 1, 0);
        tick(4'h0, 2'd3, 0, 1, 0); expect_now("after_done", 4'h3, 4'h7, 4'h9, 4'hF, 4'b0000, 0, 1);

        // partial frame, mode toggle restarts index
        tick(4'h5, 2'd3, 1, 1, 0); expect_now("part_b0",    4'h3, 4'h7, 4'h9, 4'hF, 4'b0000, 0, 1);
        tick(4'h6, 2'd3, 1, 1, 0); expect_now("part_a",     4'h5, 4'h7, 4'h9, 4'hF, 4'b0001, 0, 1);
        tick(4'h0, 2'd3, 0, 0, 0); expect_now("part_b",     4'h5, 4'h6, 4'h9, 4'hF, 4'b0011, 0, 1);
        tick(4'h0, 2'd3, 0, 1, 0); expect_now("toggle_back",4'h5, 4'h6, 4'h9, 4'hF, 4'b0011, 0, 1);
        tick(4'h8, 2'd3, 1, 1, 0); expect_now("restart_b0", 4'h5, 4'h6, 4'h9, 4'hF, 4'b0011, 0, 1);
        tick(4'h0, 2'd3, 0, 1, 0); expect_now("restart_a",  4'h8, 4'h6, 4'h9, 4'hF, 4'b0011, 0, 1);

        // clr with concurrent beat
        tick(4'hA, 2'd1, 1, 0, 1); expect_now("clr_cycle",  4'h8, 4'h6, 4'h9, 4'hF, 4'b0011, 0, 0);
        tick(4'h0, 2'd1, 0, 0, 0); expect_now("clr_after",  4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 1);

        // async reset during the 3rd auto beat
        tick(4'h1, 2'd0, 1, 1, 0); expect_now("ar_b0",      4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 1);
        tick(4'h2, 2'd0, 1, 1, 0); expect_now("ar_a",       4'h1, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1);
        tick(4'h3, 2'd0, 1, 1, 0); expect_now("ar_async",   4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0);
        #2 rst_n = 1'b0;
        tick(4'h0, 2'd0, 0, 1, 0); expect_now("ar_held",    4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 0);
        tick(4'h4, 2'd2, 1, 1, 0); rst_n = 1'b1;
                                   expect_now("ar_release", 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0, 1);
        tick(4'h0, 2'd2, 0, 1, 0); expect_now("ar_first_a", 4'h4, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1);

        // idle bus activity must not disturb anything
        for (int i = 0; i < 10; i++) begin
            tick(4'(i * 5 + 3), 2'(i), 0, 0, 0);
            expect_now("idle_hold", 4'h4, 4'h0, 4'h0, 4'h0, 4'b0001, 0, 1);
        end

        tick(4'h0, 2'd0, 0, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) $display("FAIL drain: %0d expectations left, want 0", q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
